// File: rtl/fp_encode_pkg.sv
// fp_encode_pkg: default widths, format helpers and result type for fp_encode_pipe
package fp_encode_pkg;
  localparam int IN_W_D = 12;
  localparam int EXP_W_D = 3;
  localparam int SIG_W_D = 4;
  function automatic int max_exp(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction
  typedef struct packed {
    logic               sign;
    logic [EXP_W_D-1:0] exp;
    logic [SIG_W_D-1:0] sig;
    logic               sat;
  } fp_res_t;
  localparam fp_res_t FP_SAT_D = '{sign: 1'b0, exp: '1, sig: '1, sat: 1'b1};
endpackage

// File: rtl/fp_lead_one_enc.sv
// fp_lead_one_enc: combinational index of the most significant set bit, plus found flag
module fp_lead_one_enc #(
  parameter int W = 12,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = 0; i < W; i++)
      if (i_vec[i]) begin
        o_idx = IW'(i);
        o_vld = 1'b1;
      end
  end
endmodule

// File: rtl/fp_encode_pipe.sv
// fp_encode_pipe: 3-stage linear-to-float encoder; define FP_ENCODE_RNE_EN for round-to-nearest-even
module fp_encode_pipe
  import fp_encode_pkg::*;
#(
  parameter int IN_W  = IN_W_D,
  parameter int EXP_W = EXP_W_D,
  parameter int SIG_W = SIG_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig,
  output logic             out_sat
);
  localparam int MAX_EXP = max_exp(EXP_W);
  localparam int IW = $clog2(IN_W);
  logic             r_s1_valid, r_s1_sign;
  logic [IN_W-1:0]  r_s1_mag;
  logic             r_s2_valid, r_s2_sign, r_s2_sat, r_s2_grd;
  logic [EXP_W-1:0] r_s2_exp;
  logic [SIG_W-1:0] r_s2_sig;
  logic             w_s3_load, w_s2_load, w_s1_load;
  logic [IW-1:0]    w_p, w_rsh;
  logic             w_p_vld, w_den, w_sat_pre, w_grd, w_inc, w_sat;
  logic [SIG_W:0]   w_hi, w_sum;
  logic [EXP_W-1:0] w_exp;
  logic [SIG_W-1:0] w_sig;
  logic [EXP_W:0]   w_exp_r;
  assign w_s3_load = !out_valid || out_ready;
  assign w_s2_load = !r_s2_valid || w_s3_load;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;
  fp_lead_one_enc #(.W(IN_W)) u_lead (.i_vec(r_s1_mag), .o_idx(w_p), .o_vld(w_p_vld));
  // w_hi holds the significand with the guard bit in its LSB
  always_comb begin
    w_rsh     = w_p - IW'(SIG_W);
    w_hi      = (SIG_W+1)'(r_s1_mag >> w_rsh);
    w_den     = !w_p_vld || int'(w_p) < SIG_W;
    w_sat_pre = w_p_vld && int'(w_p) >= SIG_W + MAX_EXP;
    w_exp     = w_den ? '0 : EXP_W'(int'(w_p) - SIG_W + 1);
    w_sig     = w_den ? r_s1_mag[SIG_W-1:0] : w_hi[SIG_W:1];
    w_grd     = !w_den && w_hi[0];
  end
`ifdef FP_ENCODE_RNE_EN
  logic w_stk, r_s2_stk;
  assign w_stk = !w_den && |(r_s1_mag & ((IN_W'(1) << w_rsh) - IN_W'(1)));
  assign w_inc = r_s2_grd && (r_s2_stk || r_s2_sig[0]);
  always_ff @(posedge clk)
    if (w_s2_load) r_s2_stk <= w_stk;
`else
  assign w_inc = r_s2_grd;
`endif
  always_comb begin
    w_sum   = {1'b0, r_s2_sig} + (SIG_W+1)'(w_inc);
    w_exp_r = {1'b0, r_s2_exp} + (EXP_W+1)'(w_sum[SIG_W]);
    w_sat   = r_s2_sat || w_exp_r > (EXP_W+1)'(MAX_EXP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_sign   <= 1'b0;
      out_exp    <= '0;
      out_sig    <= '0;
      out_sat    <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
        r_s1_sign  <= in_data[IN_W-1];
        r_s1_mag   <= in_data[IN_W-1] ? -in_data : in_data;
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        r_s2_sign  <= r_s1_sign;
        r_s2_sat   <= w_sat_pre;
        r_s2_exp   <= w_exp;
        r_s2_sig   <= w_sig;
        r_s2_grd   <= w_grd;
      end
      if (w_s3_load) out_valid <= r_s2_valid;
      if (w_s3_load && r_s2_valid) begin
        out_sign <= r_s2_sign;
        out_sat  <= w_sat;
        out_exp  <= w_sat ? EXP_W'(MAX_EXP) : w_exp_r[EXP_W-1:0];
        out_sig  <= w_sat ? '1 : w_sum[SIG_W] ? {1'b1, {(SIG_W-1){1'b0}}} : w_sum[SIG_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_fp_encode_pipe.sv
// tb_fp_encode_pipe: directed-vector self-checking bench for fp_encode_pipe
module tb_fp_encode_pipe;
  import fp_encode_pkg::*;
  logic        clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, out_sign, out_sat;
  logic [11:0] in_data;
  logic [2:0]  out_exp;
  logic [3:0]  out_sig;
  int          checks = 0, failures = 0, cyc = 0;
  fp_res_t     got_q[$], exp_q[$], held;
  int          got_t[$];
  fp_encode_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
    .out_sig(out_sig), .out_sat(out_sat)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      got_q.push_back('{out_sign, out_exp, out_sig, out_sat});
      got_t.push_back(cyc);
    end
  function automatic fp_res_t cur();
    return '{out_sign, out_exp, out_sig, out_sat};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [11:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    check("accept", 32'(in_ready), 1);
    @(posedge clk); #1;
  endtask
  task automatic drain(input string tag, input bit consec);
    int n = 0, i = 0, last = 0, t;
    fp_res_t r;
    while (got_q.size() < exp_q.size() && n < 60) begin @(posedge clk); n++; end
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      r = got_q.pop_front();
      t = got_t.pop_front();
      check($sformatf("%s[%0d]", tag, i), 32'(r), 32'(exp_q.pop_front()));
      if (consec && i > 0) check($sformatf("%s_gap[%0d]", tag, i), t - last, 1);
      last = t;
      i++;
    end
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1 check({tag, "_extra"}, got_q.size(), 0);
    got_q.delete();
    got_t.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_out", 32'(cur()), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    send(12'd0); send(12'd1); send(12'd2047); send(12'h800);
    in_valid = 1'b0;
    exp_q = '{fp_res_t'{1'b0, 3'd0, 4'b0000, 1'b0}, fp_res_t'{1'b0, 3'd0, 4'b0001, 1'b0},
              FP_SAT_D, fp_res_t'{1'b1, 3'd7, 4'b1111, 1'b1}};
    drain("b2b", 1'b1);
    out_ready = 1'b0;
    send(12'd422); send(12'hFFF); send(12'd62);
    in_data = 12'd42;
    @(negedge clk);
    check("stall_in_ready", 32'(in_ready), 0);
    check("stall_valid", 32'(out_valid), 1);
    held = cur();
    check("stall_head", 32'(held), 32'(fp_res_t'{1'b0, 3'd5, 4'b1101, 1'b0}));
    repeat (3) begin
      @(negedge clk);
      check("stall_hold", 32'(cur()), 32'(held));
      check("stall_in_ready_hold", 32'(in_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(12'd42); send(12'd43);
    in_valid = 1'b0;
    exp_q = '{fp_res_t'{1'b0, 3'd5, 4'b1101, 1'b0}, fp_res_t'{1'b1, 3'd0, 4'b0001, 1'b0},
              fp_res_t'{1'b0, 3'd3, 4'b1000, 1'b0},
`ifdef FP_ENCODE_RNE_EN
              fp_res_t'{1'b0, 3'd2, 4'b1010, 1'b0},
`else
              fp_res_t'{1'b0, 3'd2, 4'b1011, 1'b0},
`endif
              fp_res_t'{1'b0, 3'd2, 4'b1011, 1'b0}};
    drain("stall", 1'b0);
    out_ready = 1'b0;
    send(12'h800); send(12'd422); send(12'd62);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 1);
    check("pre_rst_head", 32'(cur()), 32'(fp_res_t'{1'b1, 3'd7, 4'b1111, 1'b1}));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_out", 32'(cur()), 0);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("no_stale", got_q.size(), 0);
    send(12'hFFF);
    in_valid = 1'b0;
    exp_q = '{fp_res_t'{1'b1, 3'd0, 4'b0001, 1'b0}};
    drain("post_rst", 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
